// File: rtl/piso_shift_pkg.sv
// Shared types and constants for the PISO shift transmitter.
// The frame length depends on PISO_PARITY_EN (adds one parity bit when defined).
package piso_shift_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 4;

   function automatic int unsigned FRAME_LEN(input int unsigned width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module piso_bit_counter #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in/serial-out transmitter, MSB first, with gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_transmitter
   import piso_shift_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D,
   input  logic             d_valid,
   output logic             d_ready,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   state_t             state, state_n;
   logic [WIDTH-1:0]   sreg, sreg_n;
   logic               sout_n, valid_n, last_n;
   logic               accept;
   logic               cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]   cnt;
`ifdef PISO_PARITY_EN
   logic               par, par_n;
`endif

   piso_bit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (CNT_W'(WIDTH - 1)),
      .en       (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   assign d_ready = shift_en & ((state == IDLE) | sout_last);
   assign accept  = d_valid & d_ready;
   assign busy    = (state != IDLE);

   always_comb begin
      state_n  = state;
      sreg_n   = sreg;
      sout_n   = sout;
      valid_n  = sout_valid;
      last_n   = sout_last;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
`ifdef PISO_PARITY_EN
      par_n    = par;
`endif
      if (shift_en) begin
         case (state)
            SHIFT: begin
               if (!cnt_zero) begin
                  sout_n  = sreg[WIDTH-1];
                  sreg_n  = {sreg[WIDTH-2:0], 1'b0};
                  cnt_dec = 1'b1;
`ifdef PISO_PARITY_EN
                  last_n  = 1'b0;
`else
                  last_n  = (cnt == CNT_W'(1));
`endif
               end else begin
`ifdef PISO_PARITY_EN
                  state_n = PARITY;
                  sout_n  = par;
                  last_n  = 1'b1;
`else
                  state_n = IDLE;
                  sout_n  = 1'b0;
                  valid_n = 1'b0;
                  last_n  = 1'b0;
`endif
               end
            end
            PARITY: begin
               state_n = IDLE;
               sout_n  = 1'b0;
               valid_n = 1'b0;
               last_n  = 1'b0;
            end
            default: ;
         endcase
         // Acceptance only happens in IDLE or on the last bit, so it overrides the frame-end path.
         if (accept) begin
            state_n  = SHIFT;
            sout_n   = D[WIDTH-1];
            sreg_n   = {D[WIDTH-2:0], 1'b0};
            valid_n  = 1'b1;
            last_n   = 1'b0;
            cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
            par_n    = ^D;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sreg       <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_last  <= 1'b0;
`ifdef PISO_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sreg       <= sreg_n;
         sout       <= sout_n;
         sout_valid <= valid_n;
         sout_last  <= last_n;
`ifdef PISO_PARITY_EN
         par        <= par_n;
`endif
      end
   end

endmodule
